// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sizes, opcodes, mem_op codes, fetch FSM states
// and the instruction word layout used by the fetch/decode front end.
package cpu_pkg;

  localparam int DATA_SIZE  = 16;
  localparam int ADDR_SIZE  = 5;
  localparam int STACK_SIZE = 4;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_INC = 4'h3;
  localparam logic [3:0] OP_LD  = 4'h8;
  localparam logic [3:0] OP_ST  = 4'h9;
  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [3:0] OP_RTN = 4'hD;

  localparam logic [3:0] NONE       = 4'h0;
  localparam logic [3:0] REG_TO_REG = 4'h1;
  localparam logic [3:0] MEM_TO_REG = 4'h2;
  localparam logic [3:0] OP_REG     = 4'h3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [3:0] op_code;
    logic [3:0] mem_op;
    logic [3:0] left;
    logic [3:0] right;
  } instr_t;

  // Jump target is the low PC bits of the {left,right} byte.
  function automatic logic [ADDR_SIZE-1:0] jump_target(input instr_t ins);
    return ADDR_SIZE'({ins.left, ins.right});
  endfunction

endpackage

// File: rtl/instr_fetch_decode_ret_stack.sv
// Return-address LIFO. One operation per cycle; clear wins, a push into a
// full stack and a pop from an empty stack are ignored (the caller flags them).
module ret_stack
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [IW-1:0]    wr_idx_s;
  logic [IW-1:0]    top_idx_s;

  assign full      = (cnt_q == CW'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign wr_idx_s  = IW'(cnt_q);
  assign top_idx_s = IW'(cnt_q - CW'(1));
  assign top       = empty ? '0 : mem_q[top_idx_s];

  // Next stack contents and fill count for the requested operation.
  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (push && !full) begin
      mem_d[wr_idx_s] = push_data;
      cnt_d           = cnt_q + CW'(1);
    end else if (pop && !empty) begin
      cnt_d = cnt_q - CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Stack storage and count; reset empties the stack.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/instr_fetch_decode.sv
// Instruction fetch/decode front end: fetches from a synchronous-read program
// memory, resolves JMP/RTN locally via a return stack, and presents all other
// instructions to execute over valid/ready. load suspends and restarts fetch.
module instr_fetch_decode
  import cpu_pkg::*;
#(
  parameter int DATA_SIZE  = cpu_pkg::DATA_SIZE,
  parameter int ADDR_SIZE  = cpu_pkg::ADDR_SIZE,
  parameter int STACK_SIZE = cpu_pkg::STACK_SIZE
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 load,
  output logic                 mem_rd,
  output logic [ADDR_SIZE-1:0] mem_addr,
  input  logic [DATA_SIZE-1:0] mem_rdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           out_opcode,
  output logic [3:0]           out_memop,
  output logic [3:0]           out_left,
  output logic [3:0]           out_right,
  output logic [ADDR_SIZE-1:0] out_pc,
  output logic                 stack_err
);

  fetch_state_e         state_q, state_d;
  logic [ADDR_SIZE-1:0] pc_q, pc_d;
  instr_t               ir_q, ir_d;
  logic                 err_q, err_d;

  instr_t               rd_s;
  logic                 push_s, pop_s, clear_s;
  logic [ADDR_SIZE-1:0] stk_top_s;
  logic                 stk_full_s, stk_empty_s;
  logic [ADDR_SIZE-1:0] pc_inc_s;

  assign rd_s     = instr_t'(mem_rdata);
  assign pc_inc_s = pc_q + ADDR_SIZE'(1);

  ret_stack #(
    .DEPTH(STACK_SIZE),
    .WIDTH(ADDR_SIZE)
  ) u_ret_stack (
    .clk      (clk),
    .rstn     (rstn),
    .clear    (clear_s),
    .push     (push_s),
    .pop      (pop_s),
    .push_data(pc_inc_s),
    .top      (stk_top_s),
    .full     (stk_full_s),
    .empty    (stk_empty_s)
  );

  // FSM next state, PC/IR updates and stack control; load overrides everything.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    err_d   = err_q;
    push_s  = 1'b0;
    pop_s   = 1'b0;
    clear_s = 1'b0;
    if (load) begin
      state_d = ST_IDLE;
      pc_d    = '0;
      ir_d    = '0;
      err_d   = 1'b0;
      clear_s = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          pc_d    = '0;
          state_d = ST_FETCH;
        end
        ST_FETCH: begin
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          ir_d = rd_s;
          case (rd_s.op_code)
            OP_JMP: begin
              push_s  = 1'b1;
              pc_d    = jump_target(rd_s);
              state_d = ST_FETCH;
              if (stk_full_s) begin
                err_d = 1'b1;
              end else begin
                err_d = err_q;
              end
            end
            OP_RTN: begin
              pop_s   = 1'b1;
              state_d = ST_FETCH;
              if (stk_empty_s) begin
                pc_d  = '0;
                err_d = 1'b1;
              end else begin
                pc_d  = stk_top_s;
                err_d = err_q;
              end
            end
            default: begin
              state_d = ST_HOLD;
            end
          endcase
        end
        ST_HOLD: begin
          if (out_ready) begin
            pc_d    = pc_inc_s;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_HOLD;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Front-end state registers; reset returns to IDLE with PC, IR and flag cleared.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
    end
  end

  assign mem_rd     = (state_q == ST_FETCH);
  assign mem_addr   = pc_q;
  assign out_valid  = (state_q == ST_HOLD);
  assign out_opcode = ir_q.op_code;
  assign out_memop  = ir_q.mem_op;
  assign out_left   = ir_q.left;
  assign out_right  = ir_q.right;
  assign out_pc     = pc_q;
  assign stack_err  = err_q;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed bench for instr_fetch_decode: a table of expected presented
// instructions for a straight-line/jump/return/wrap program, plus hand-written
// sequences for backpressure, stack overflow/underflow, async reset and load.
module tb_instr_fetch_decode;

  logic        clk;
  logic        rstn;
  logic        load;
  logic        mem_rd;
  logic [4:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_opcode, out_memop, out_left, out_right;
  logic [4:0]  out_pc;
  logic        stack_err;

  logic [15:0] prog [0:31];
  int          n_vec;
  int          n_err;
  int          bad_present;

  typedef struct {
    string       name;
    int          gap;
    logic [4:0]  pc;
    logic [15:0] word;
    logic        err;
  } vec_t;

  vec_t tbl [10];

  instr_fetch_decode dut (
    .clk       (clk),
    .rstn      (rstn),
    .load      (load),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_opcode(out_opcode),
    .out_memop (out_memop),
    .out_left  (out_left),
    .out_right (out_right),
    .out_pc    (out_pc),
    .stack_err (stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read program memory.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= prog[mem_addr];
  end

  // Branch instructions must never be presented downstream.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && (out_opcode == 4'hC || out_opcode == 4'hD))
      bad_present++;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic clear_prog();
    for (int i = 0; i < 32; i++) prog[i] = 16'h0000;
  endtask

  task automatic check_reset(input string name);
    n_vec++;
    if (mem_rd !== 1'b0 || mem_addr !== 5'd0 || out_valid !== 1'b0 ||
        {out_opcode, out_memop, out_left, out_right} !== 16'h0000 ||
        out_pc !== 5'd0 || stack_err !== 1'b0) begin
      n_err++;
      $display("FAIL %s: got rd=%b addr=%0d valid=%b word=%h pc=%0d err=%b, want all zero",
               name, mem_rd, mem_addr, out_valid,
               {out_opcode, out_memop, out_left, out_right}, out_pc, stack_err);
    end
  endtask

  // Wait for the next presented instruction and compare it with the expectation.
  task automatic expect_next(input string name, input int exp_gap, input logic [4:0] exp_pc,
                             input logic [15:0] exp_word, input logic exp_err);
    int cyc;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (out_valid !== 1'b1 && cyc < 40);
    n_vec++;
    if (out_valid !== 1'b1 || cyc != exp_gap || out_pc !== exp_pc ||
        {out_opcode, out_memop, out_left, out_right} !== exp_word || stack_err !== exp_err) begin
      n_err++;
      $display("FAIL %s: got valid=%b gap=%0d pc=%0d word=%h err=%b, want gap=%0d pc=%0d word=%h err=%b",
               name, out_valid, cyc, out_pc, {out_opcode, out_memop, out_left, out_right},
               stack_err, exp_gap, exp_pc, exp_word, exp_err);
    end
  endtask

  task automatic release_load();
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  initial begin
    logic [15:0] held;
    n_vec = 0; n_err = 0; bad_present = 0;
    tbl[0] = '{"inc_pc0",      3, 5'd0,  16'h3021, 1'b0};
    tbl[1] = '{"add_pc1",      3, 5'd1,  16'h1032, 1'b0};
    tbl[2] = '{"nop_pc2",      3, 5'd2,  16'h0102, 1'b0};
    tbl[3] = '{"jmp_jmp_pc11", 7, 5'd11, 16'h2345, 1'b0};
    tbl[4] = '{"ld_pc12",      3, 5'd12, 16'h8211, 1'b0};
    tbl[5] = '{"rtn_to_pc10",  5, 5'd10, 16'h9A5F, 1'b0};
    tbl[6] = '{"sub_pc11",     3, 5'd11, 16'h2345, 1'b0};
    tbl[7] = '{"ld_pc12_b",    3, 5'd12, 16'h8211, 1'b0};
    tbl[8] = '{"rtn_jmp_pc31", 7, 5'd31, 16'h3000, 1'b0};
    tbl[9] = '{"wrap_pc0",     3, 5'd0,  16'h3021, 1'b0};

    // Reset with load held, then program the main image.
    load = 1'b1; out_ready = 1'b0; rstn = 1'b1;
    clear_prog();
    #2;
    check_reset("reset_values");
    #10 rstn = 1'b0;
    prog[0]  = 16'h3021; prog[1]  = 16'h1032; prog[2]  = 16'h0102;
    prog[3]  = 16'hC009; prog[4]  = 16'hC01F; prog[9]  = 16'hC00B;
    prog[10] = 16'h9A5F; prog[11] = 16'h2345; prog[12] = 16'h8211;
    prog[13] = 16'hD300; prog[31] = 16'h3000;
    @(posedge clk); #1;
    out_ready = 1'b1;
    release_load();

    // Straight line, jump/return and PC wrap with ready held high.
    for (int i = 0; i < 10; i++) begin
      expect_next(tbl[i].name, tbl[i].gap, tbl[i].pc, tbl[i].word, tbl[i].err);
    end
    out_ready = 1'b0;
    n_vec++;
    if (bad_present != 0) begin
      n_err++;
      $display("FAIL no_branch_presented: got %0d branch presentations, want 0", bad_present);
    end

    // Backpressure on word 0x0102.
    load = 1'b1;
    clear_prog();
    prog[0] = 16'h0102; prog[1] = 16'h3021;
    release_load();
    expect_next("bp_first", 3, 5'd0, 16'h0102, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      held = {out_opcode, out_memop, out_left, out_right};
      n_vec++;
      if (out_valid !== 1'b1 || held !== 16'h0102 || out_memop !== 4'd1 ||
          out_pc !== 5'd0 || mem_rd !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold%0d: got valid=%b word=%h pc=%0d rd=%b, want valid=1 word=0102 pc=0 rd=0",
                 i, out_valid, held, out_pc, mem_rd);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (out_valid !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 5'd1) begin
      n_err++;
      $display("FAIL bp_accept: got valid=%b rd=%b addr=%0d, want valid=0 rd=1 addr=1",
               out_valid, mem_rd, mem_addr);
    end
    expect_next("bp_next", 2, 5'd1, 16'h3021, 1'b0);
    out_ready = 1'b0;

    // Five nested jumps overflow a four-entry stack.
    load = 1'b1;
    clear_prog();
    prog[0] = 16'hC002; prog[2] = 16'hC004; prog[4] = 16'hC006;
    prog[6] = 16'hC008; prog[8] = 16'hC00A; prog[10] = 16'h3000;
    release_load();
    expect_next("overflow", 13, 5'd10, 16'h3000, 1'b1);

    // Async reset mid-HOLD: immediate reset values, stack emptied.
    load = 1'b1;
    rstn = 1'b1;
    #1;
    check_reset("async_reset");
    clear_prog();
    prog[0] = 16'h3000; prog[1] = 16'hD000;
    #2 rstn = 1'b0;
    out_ready = 1'b1;
    release_load();
    expect_next("underflow_first", 3, 5'd0, 16'h3000, 1'b0);
    expect_next("underflow_ret", 5, 5'd0, 16'h3000, 1'b1);
    out_ready = 1'b0;

    // load while holding with ready low: drop valid, clear error, refetch from 0.
    @(posedge clk); #1;
    load = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (out_valid !== 1'b0 || stack_err !== 1'b0 || mem_rd !== 1'b0 || mem_addr !== 5'd0) begin
      n_err++;
      $display("FAIL load_hold: got valid=%b err=%b rd=%b addr=%0d, want 0 0 0 0",
               out_valid, stack_err, mem_rd, mem_addr);
    end
    prog[0] = 16'h1032;
    release_load();
    expect_next("load_refetch", 3, 5'd0, 16'h1032, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_decode.md
# instr_fetch_decode

Instruction fetch/decode front end of the CPU core. Reads 16-bit instruction words from the program memory over its read port, splits them into {op_code, mem_op, left, right}, and hands each decoded instruction to the execute stage over a valid/ready handshake. It resolves OP_JMP and OP_RTN locally using a return-address stack, and is suspended while the program memory is being loaded through the write port.

## Interface
- DATA_SIZE, 16, instruction word width; field layout is [15:12] op_code, [11:8] mem_op, [7:4] left, [3:0] right.
- ADDR_SIZE, 5, program memory address width; also the PC width.
- STACK_SIZE, 4, return-address stack depth in entries.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-high.
- load  in  1  program memory is being written; fetch is suspended while high.
- mem_rd  out  1  read strobe to program memory.
- mem_addr  out  ADDR_SIZE  read address, equal to the PC.
- mem_rdata  in  DATA_SIZE  read data, valid one cycle after mem_rd.
- out_valid  out  1  decoded instruction available.
- out_ready  in  1  execute stage accepts.
- out_opcode, out_memop, out_left, out_right  out  4 each  decoded fields.
- out_pc  out  ADDR_SIZE  address of the presented instruction.
- stack_err  out  1  sticky flag for return-stack overflow or underflow.

## Operation
- FSM states are IDLE, FETCH, WAIT and HOLD.
- IDLE: entered on reset or while load=1. PC=0, stack empty. Exits to FETCH on the first cycle with load=0.
- FETCH: mem_rd=1, mem_addr=PC. Always goes to WAIT.
- WAIT: mem_rdata is captured into IR at the closing edge, and the opcode decides the next state:
  - OP_JMP: push PC+1, set PC to {left,right}[ADDR_SIZE-1:0], go to FETCH. Not presented downstream.
  - OP_RTN: pop into PC, go to FETCH. Not presented downstream.
  - Otherwise: go to HOLD.
- HOLD: out_valid=1 with fields from IR and out_pc=PC.
  - On out_valid && out_ready: PC becomes PC+1, go to FETCH.
  - Without ready: stay in HOLD with all outputs stable.
- PC arithmetic is modulo 2^ADDR_SIZE, so 31+1 wraps to 0.
- Push when the stack is full: jump is still taken, the push is dropped, stack_err is set.
- Pop when the stack is empty: PC becomes 0, stack_err is set.
- load=1 in any state: go to IDLE next cycle.
  - out_valid drops and any pending instruction is discarded.
  - Stack is cleared and stack_err is cleared.
  - Takes priority over every other transition.
- stack_err is cleared only by reset or load.
- All mem_op values are passed through untouched. Decoding them is the execute stage's job.

## Timing
- Reset values: mem_rd=0, mem_addr=0, out_valid=0, all out_* fields=0, out_pc=0, stack_err=0, state=IDLE.
- Synchronous-read memory: address is sampled at the end of FETCH cycle N, data is valid during N+1 and captured at the end of N+1.
- Latency from leaving IDLE to the first out_valid is 3 cycles (FETCH, WAIT, HOLD).
- Back-to-back throughput with out_ready=1 is one instruction per 3 cycles.
- A JMP or RTN costs 2 cycles (FETCH, WAIT) before the target fetch.
- out_valid never depends combinationally on out_ready. All outputs are registered or decoded from state.
- Asynchronous reset mid-operation forces the reset values immediately. The stack is emptied.

## Structure
- Shared package cpu_pkg holds:
  - Opcodes: OP_NOP=0, OP_ADD=1, OP_SUB=2, OP_INC=3, OP_LD=8, OP_ST=9, OP_JMP=4'hC, OP_RTN=4'hD.
  - mem_op codes: NONE=0, REG_TO_REG=1, MEM_TO_REG=2, OP_REG=3.
  - The fetch state enum.
- Sub-module ret_stack: a STACK_SIZE×ADDR_SIZE LIFO with push, pop, full, empty and clear, one operation per cycle.

## Test plan
- Straight-line fetch:
  - Load words 0x3021 (INC) and 0x1032 (ADD), drop load, hold out_ready=1.
  - Expect out_valid 3 cycles after load falls with opcode=3, left=2, right=1, pc=0.
  - Expect the next instruction 3 cycles later with opcode=1, pc=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles on a word 0x0102.
  - Expect out_valid held, fields stable (memop=1, left=0, right=2) and no mem_rd.
  - After ready rises, expect a single transfer.
- Jump and return:
  - Program addr 9 with 0xC00B (JMP to 11), addr 13 with 0xD300.
  - Expect 11 and 12 presented, then return to 10 with JMP and RTN never presented.
- Stack overflow and underflow:
  - Run 5 nested JMPs with STACK_SIZE=4; expect stack_err=1 and all jumps taken.
  - After reset, run an RTN on an empty stack; expect PC=0 and stack_err=1.
- load mid-HOLD with out_ready=0: expect out_valid=0 the next cycle, stack_err cleared, and refetch from address 0 after load falls.
- PC wrap: a non-branch at address 31 is accepted, and the next fetch uses mem_addr=0.
